// File: rtl/wb_sram_slave_if.sv
// Wishbone classic bus bundle between one master and the SRAM responder.
interface wb_sram_slave_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, we, stb, cyc,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, stb, cyc,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone classic responder in front of a 32-bit synchronous SRAM with byte-lane writes,
// programmable wait states and an optional error response outside the address window.
module wb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          ERR_EN      = 1'b1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_sram_slave_if.slave  wb
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdat_q;
  logic [3:0]              sel_q;
  logic                    we_q;
  logic                    inwin_q;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [31:0]             rdat_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  req;
  logic                  in_win;
  logic                  latch;
  logic                  enter_resp;
  logic                  cur_ok;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [31:0]           cur_wdat;
  logic [3:0]            cur_sel;
  logic                  mem_we;
  logic                  rd_hit;
  logic                  rd_err;

  // Byte-offset and interconnect-decoded bits carry no meaning here.
  logic unused_adr;
  assign unused_adr = ^{wb.adr[31:28], wb.adr[1:0]};

  assign req    = wb.cyc & wb.stb;
  assign in_win = (wb.adr[27:ADDR_WIDTH+2] == '0);

  // With no wait states RESP is entered from IDLE, so the live bus values are used directly.
  always_comb begin
    if (state_q == StIdle) begin
      cur_idx  = wb.adr[ADDR_WIDTH+1:2];
      cur_wdat = wb.dat_w;
      cur_sel  = wb.sel;
      cur_we   = wb.we;
      cur_ok   = in_win | ~ERR_EN;
    end else begin
      cur_idx  = idx_q;
      cur_wdat = wdat_q;
      cur_sel  = sel_q;
      cur_we   = we_q;
      cur_ok   = inwin_q | ~ERR_EN;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          latch = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    enter_resp = (state_d == StResp) && (state_q != StResp);
    ack_d      = enter_resp & cur_ok;
    err_d      = enter_resp & ~cur_ok;
    mem_we     = ack_d & cur_we;
    rd_hit     = ack_d & ~cur_we;
    rd_err     = err_d & ~cur_we;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      inwin_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (latch) begin
        idx_q   <= wb.adr[ADDR_WIDTH+1:2];
        wdat_q  <= wb.dat_w;
        sel_q   <= wb.sel;
        we_q    <= wb.we;
        inwin_q <= in_win;
      end
    end
  end

  // RAM array and read register; reset suppresses writes but never clears contents.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      rdat_q <= '0;
    end else begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++) begin
          if (cur_sel[i]) mem[cur_idx][8*i +: 8] <= cur_wdat[8*i +: 8];
        end
      end
      if (rd_hit) begin
        rdat_q <= mem[cur_idx];
      end else if (rd_err) begin
        rdat_q <= '0;
      end
    end
  end

  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.dat_r = rdat_q;

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
- Wishbone classic responder fronting an on-chip synchronous SRAM; connects to one slave port (sN_*) of the Wishbone interconnect.
- Serves the CPU instruction and data masters as a fast scratch/boot RAM beside the SDRAM, flash, UART and GPIO slaves.
- Provides byte-lane writes, a programmable number of wait states, and an error response for addresses outside its window.

Parameters:
- ADDR_WIDTH, 12, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_STATES, 0, extra cycles between request acceptance and the ack/err cycle; legal range 0..15.
- ERR_EN, 1, 1 = out-of-window access answers with wb_err_o; 0 = the address wraps and is acked.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-low reset.
- wb_adr_i  in  32  byte address; bits [31:28] are decoded by the interconnect and ignored here.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte lanes; bit0 = bits [7:0].
- wb_we_i  in  1  1 = write.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.

Behaviour:
Reset:
- wb_rst_i low at a rising edge puts the FSM in IDLE and clears the wait counter, wb_ack_o, wb_err_o and wb_dat_o to 0.
- RAM contents are not cleared.
- Reset asserted mid-transaction aborts it: no write, no termination.

Request decode:
- A request is valid when wb_cyc_i & wb_stb_i.
- Word index = wb_adr_i[ADDR_WIDTH+1:2]; wb_adr_i[1:0] are ignored.
- In-window means wb_adr_i[27:ADDR_WIDTH+2] == 0.

FSM states IDLE, WAIT, RESP:
- IDLE: on a valid request, latch address, we, sel, wdata and the in-window flag. Go to WAIT with counter = WAIT_STATES-1 if WAIT_STATES > 0, else go to RESP.
- WAIT: decrement the counter; at 0 go to RESP. If cyc or stb drops in WAIT, go to IDLE with no write and no termination.
- RESP: exactly one of wb_ack_o / wb_err_o is high for exactly one cycle, then the FSM returns to IDLE unconditionally.
- IDLE always spends at least one cycle between transactions, so back-to-back requests take WAIT_STATES+2 cycles each.

Latency:
- Request first seen in IDLE at cycle N gives termination high in cycle N+1+WAIT_STATES.

Write:
- Committed at the rising edge that enters RESP, only if in-window (or ERR_EN = 0).
- Each byte lane is written only where its wb_sel_i bit is 1.
- sel = 0000 is acked with no RAM change.
- Error accesses never write.

Read:
- wb_dat_o carries the addressed word during the RESP cycle.
- wb_dat_o holds that value until the next read RESP; writes do not update it.
- On an error read, wb_dat_o = 0.

Out-of-window:
- ERR_EN = 1: wb_err_o is pulsed in place of wb_ack_o, with identical timing.
- ERR_EN = 0: the upper address bits are ignored (address wraps) and the access is acked.

Further rules:
- wb_ack_o and wb_err_o are never high together.
- Both are registered outputs, low in every state except RESP.
- Inputs changing during WAIT, other than the abort condition, have no effect; the latched values are used.

Test Plan:
1. Write 0xDEADBEEF to 0x0000_0010 with sel=1111, then read 0x0000_0010 (WAIT_STATES=0) -> ack high 1 cycle after each request; read returns 0xDEADBEEF; err stays 0.
2. Write 0x000000AA to 0x0000_0010 with sel=0001, then read -> 0xDEADBEAA. Write with sel=0000, then read -> still 0xDEADBEAA.
3. WAIT_STATES=3, read 0x0000_3FFC (last word) -> ack exactly 4 cycles after the request-seen cycle; one cycle wide; data = last written value.
4. Read 0x0000_4000 with ERR_EN=1 -> err pulse at ack timing, ack=0, wb_dat_o=0. Write to 0x0000_4000 with data 0x12345678 -> err; word 0 is unchanged. With ERR_EN=0, a read of 0x0000_4000 acks with the contents of word 0.
5. WAIT_STATES=3: drop stb during WAIT on a write of 0x55 -> no ack, no err, RAM unchanged; the next request is accepted normally.
6. Assert wb_rst_i=0 during RESP of a read -> the next cycle has ack=0 and wb_dat_o=0; after release, previously written RAM data reads back intact.
